// File: rtl/uart_cmd_ctrl_if.sv
// Parallel-side bus of the UART command controller: RX byte input, TX byte
// output and the register-file port.
interface uart_cmd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic [ADDR_WIDTH-1:0] REG_ADDR;
  logic                  REG_WR_EN;
  logic [DATA_WIDTH-1:0] REG_WR_DATA;
  logic                  REG_RD_EN;
  logic [DATA_WIDTH-1:0] REG_RD_DATA;
  logic                  REG_RD_VLD;
  logic                  CMD_ERROR;
  logic                  CTRL_BUSY;

  // Controller side
  modport master (
    input  RX_P_DATA, RX_D_VLD, TX_BUSY, REG_RD_DATA, REG_RD_VLD,
    output TX_P_DATA, TX_D_VLD, REG_ADDR, REG_WR_EN, REG_WR_DATA,
           REG_RD_EN, CMD_ERROR, CTRL_BUSY
  );

  // UART / register-file side
  modport slave (
    output RX_P_DATA, RX_D_VLD, TX_BUSY, REG_RD_DATA, REG_RD_VLD,
    input  TX_P_DATA, TX_D_VLD, REG_ADDR, REG_WR_EN, REG_WR_DATA,
           REG_RD_EN, CMD_ERROR, CTRL_BUSY
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes write/read frames from the received byte
// stream, drives the register-file port and returns read data to the TX side.
module uart_cmd_ctrl #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter int unsigned           TIMEOUT    = 1000
) (
  input logic             CLK,
  input logic             RST,
  uart_cmd_ctrl_if.master bus
);

  localparam int unsigned      CNT_W       = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
  logic                  tx_d_vld_q, tx_d_vld_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
  logic                  reg_rd_en_q, reg_rd_en_d;
  logic                  cmd_error_q, cmd_error_d;
  logic                  ctrl_busy_q, ctrl_busy_d;

  logic                  rx_vld;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  timed;

  assign rx_vld  = bus.RX_D_VLD;
  assign rx_byte = bus.RX_P_DATA;

  // Frame decode, strobe generation and mid-frame timeout
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_p_data_d   = tx_p_data_q;
    tx_d_vld_d    = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_data_d = reg_wr_data_q;
    reg_rd_en_d   = 1'b0;
    cmd_error_d   = 1'b0;
    timed         = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                    (state_q == RD_ADDR) || (state_q == RD_WAIT);

    unique case (state_q)
      IDLE: begin
        if (rx_vld) begin
          if (rx_byte == WR_CMD)      state_d = WR_ADDR;
          else if (rx_byte == RD_CMD) state_d = RD_ADDR;
          else                        cmd_error_d = 1'b1;
        end
      end
      WR_ADDR: begin
        if (rx_vld) begin
          reg_addr_d = rx_byte[ADDR_WIDTH-1:0];
          state_d    = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_vld) begin
          reg_wr_en_d   = 1'b1;
          reg_wr_data_d = rx_byte;
          state_d       = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_vld) begin
          reg_addr_d  = rx_byte[ADDR_WIDTH-1:0];
          reg_rd_en_d = 1'b1;
          state_d     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Bytes arriving while a read is in flight are dropped
        if (rx_vld) cmd_error_d = 1'b1;
        if (bus.REG_RD_VLD) begin
          tx_p_data_d = bus.REG_RD_DATA;
          state_d     = TX_SEND;
        end
      end
      TX_SEND: begin
        if (rx_vld) cmd_error_d = 1'b1;
        if (!bus.TX_BUSY) begin
          tx_d_vld_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte or a state change in the abort cycle takes priority over the timeout
    if (TIMEOUT_EN && timed && !rx_vld && (state_d == state_q) &&
        (cnt_q == TIMEOUT_CNT)) begin
      state_d     = IDLE;
      cmd_error_d = 1'b1;
    end

    if (!timed || rx_vld || (state_d != state_q)) cnt_d = '0;
    else if (TIMEOUT_EN)                          cnt_d = cnt_q + CNT_W'(1);

    ctrl_busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_p_data_q   <= '0;
      tx_d_vld_q    <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= '0;
      reg_rd_en_q   <= 1'b0;
      cmd_error_q   <= 1'b0;
      ctrl_busy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_p_data_q   <= tx_p_data_d;
      tx_d_vld_q    <= tx_d_vld_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_rd_en_q   <= reg_rd_en_d;
      cmd_error_q   <= cmd_error_d;
      ctrl_busy_q   <= ctrl_busy_d;
    end
  end

  assign bus.TX_P_DATA   = tx_p_data_q;
  assign bus.TX_D_VLD    = tx_d_vld_q;
  assign bus.REG_ADDR    = reg_addr_q;
  assign bus.REG_WR_EN   = reg_wr_en_q;
  assign bus.REG_WR_DATA = reg_wr_data_q;
  assign bus.REG_RD_EN   = reg_rd_en_q;
  assign bus.CMD_ERROR   = cmd_error_q;
  assign bus.CTRL_BUSY   = ctrl_busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames plus randomized frames checked
// against a frame-level model (expected strobe cycles and register contents).
module tb_uart_cmd_ctrl;

  localparam int unsigned TO = 25;

  typedef struct {
    int         c;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         rd_delay = 1;
  int         rd_cnt = -1;
  logic [3:0] rd_addr = 4'h0;
  bit         env_ready = 1'b0;
  logic [7:0] env_regs [16];
  logic [7:0] ref_regs [16];
  ev_t        wr_q[$];
  ev_t        rd_q[$];
  ev_t        tx_q[$];
  int         err_q[$];
  int         multi_strobe = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_cmd_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Register-file model and output event recorder
  always @(negedge CLK) begin
    ev_t e;
    if (!env_ready) begin
      for (int i = 0; i < 16; i++) env_regs[i] = 8'($urandom);
      env_regs[5] = 8'h3C;
      env_regs[7] = 8'hA5;
      env_regs[9] = 8'h96;
      bus.REG_RD_DATA = 8'h00;
      env_ready = 1'b1;
    end
    bus.REG_RD_VLD = 1'b0;
    if (!RST) rd_cnt = -1;
    else if (rd_cnt == 0) begin
      bus.REG_RD_VLD  = 1'b1;
      bus.REG_RD_DATA = env_regs[rd_addr];
      rd_cnt = -1;
    end else if (rd_cnt > 0) rd_cnt--;
    e.c = cyc;
    e.a = 8'(bus.REG_ADDR);
    e.d = bus.REG_WR_DATA;
    if (bus.REG_WR_EN === 1'b1) begin
      wr_q.push_back(e);
      env_regs[bus.REG_ADDR] = bus.REG_WR_DATA;
    end
    if (bus.REG_RD_EN === 1'b1) begin
      rd_q.push_back(e);
      rd_addr = bus.REG_ADDR;
      if (rd_delay == 0) begin
        bus.REG_RD_VLD  = 1'b1;
        bus.REG_RD_DATA = env_regs[rd_addr];
      end else if (rd_delay > 0) rd_cnt = rd_delay - 1;
    end
    if (bus.TX_D_VLD === 1'b1) begin
      e.d = bus.TX_P_DATA;
      tx_q.push_back(e);
    end
    if (bus.CMD_ERROR === 1'b1) err_q.push_back(cyc);
    if (int'(bus.REG_WR_EN) + int'(bus.REG_RD_EN) + int'(bus.TX_D_VLD) > 1) multi_strobe++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d did not complete", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [24:0] all_outs();
    return {bus.TX_P_DATA, bus.TX_D_VLD, bus.REG_ADDR, bus.REG_WR_EN, bus.REG_WR_DATA,
            bus.REG_RD_EN, bus.CMD_ERROR, bus.CTRL_BUSY};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, output int c);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    c = cyc;
    tick();
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'($urandom);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;
    bus.TX_BUSY   = 1'b0;
    idle(3);
    total++;
    if (all_outs() !== 25'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
    RST = 1'b1;
    idle(2);
    total++;
    if (bus.CTRL_BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_idle ctrl_busy got=%b want=0", bus.CTRL_BUSY);
    end
  endtask

  task automatic test_write();
    int w0, e0, r0, t0, c, c3;
    w0 = wr_q.size(); e0 = err_q.size(); r0 = rd_q.size(); t0 = tx_q.size();
    send_byte(8'hAA, c);
    total++;
    if (bus.CTRL_BUSY !== 1'b1) begin
      bad++; $display("FAIL write_busy got=%b want=1", bus.CTRL_BUSY);
    end
    idle(19);
    send_byte(8'h03, c);
    idle(19);
    send_byte(8'h5C, c3);
    idle(3);
    total++;
    if (wr_q.size() - w0 != 1) begin
      bad++; $display("FAIL write_count got=%0d want=1", wr_q.size() - w0);
    end else begin
      total++;
      if (wr_q[w0].c != c3 + 1) begin
        bad++; $display("FAIL write_cycle got=%0d want=%0d", wr_q[w0].c, c3 + 1);
      end
      total++;
      if (wr_q[w0].a !== 8'h03 || wr_q[w0].d !== 8'h5C) begin
        bad++; $display("FAIL write_payload got=%h/%h want=03/5c", wr_q[w0].a, wr_q[w0].d);
      end
    end
    total++;
    if (err_q.size() != e0 || rd_q.size() != r0 || tx_q.size() != t0) begin
      bad++; $display("FAIL write_side err=%0d rd=%0d tx=%0d want=0", err_q.size() - e0,
                      rd_q.size() - r0, tx_q.size() - t0);
    end
    total++;
    if (bus.CTRL_BUSY !== 1'b0) begin
      bad++; $display("FAIL write_end_busy got=%b want=0", bus.CTRL_BUSY);
    end
  endtask

  task automatic test_read();
    int r0, t0, e0, c, b;
    r0 = rd_q.size(); t0 = tx_q.size(); e0 = err_q.size();
    rd_delay = 2;
    bus.TX_BUSY = 1'b0;
    send_byte(8'hBB, c);
    idle(2);
    send_byte(8'h07, b);
    idle(10);
    total++;
    if (rd_q.size() - r0 != 1 || rd_q[rd_q.size()-1].c != b + 1 || rd_q[rd_q.size()-1].a !== 8'h07) begin
      bad++; $display("FAIL read_strobe n=%0d want 1 at %0d addr 07", rd_q.size() - r0, b + 1);
    end
    total++;
    if (tx_q.size() - t0 != 1) begin
      bad++; $display("FAIL read_tx_count got=%0d want=1", tx_q.size() - t0);
    end else begin
      total++;
      if (tx_q[t0].c != b + 5 || tx_q[t0].d !== 8'hA5) begin
        bad++; $display("FAIL read_tx got=%0d/%h want=%0d/a5", tx_q[t0].c, tx_q[t0].d, b + 5);
      end
    end
    total++;
    if (bus.CTRL_BUSY !== 1'b0 || err_q.size() != e0 || bus.TX_P_DATA !== 8'hA5) begin
      bad++; $display("FAIL read_end busy=%b err=%0d txd=%h want 0/0/a5", bus.CTRL_BUSY,
                      err_q.size() - e0, bus.TX_P_DATA);
    end
  endtask

  task automatic test_tx_busy();
    int t0, c, b, p;
    t0 = tx_q.size();
    rd_delay = 1;
    bus.TX_BUSY = 1'b1;
    send_byte(8'hBB, c);
    send_byte(8'h09, b);
    p = b + 3;
    while (cyc < p + 50) tick();
    total++;
    if (tx_q.size() != t0 || bus.TX_P_DATA !== 8'h96) begin
      bad++; $display("FAIL txbusy_hold tx=%0d txd=%h want 0/96", tx_q.size() - t0, bus.TX_P_DATA);
    end
    bus.TX_BUSY = 1'b0;
    idle(5);
    total++;
    if (tx_q.size() - t0 != 1) begin
      bad++; $display("FAIL txbusy_count got=%0d want=1", tx_q.size() - t0);
    end else begin
      total++;
      if (tx_q[t0].c != p + 51 || tx_q[t0].d !== 8'h96) begin
        bad++; $display("FAIL txbusy_send got=%0d/%h want=%0d/96", tx_q[t0].c, tx_q[t0].d, p + 51);
      end
    end
  endtask

  task automatic test_unknown();
    int w0, e0, c0, c, c3;
    w0 = wr_q.size(); e0 = err_q.size();
    send_byte(8'h12, c0);
    idle(2);
    send_byte(8'hAA, c); idle(2);
    send_byte(8'hF1, c); idle(2);
    send_byte(8'h00, c3);
    idle(3);
    total++;
    if (err_q.size() - e0 != 1 || err_q[err_q.size()-1] != c0 + 1) begin
      bad++; $display("FAIL unknown_err n=%0d want 1 at %0d", err_q.size() - e0, c0 + 1);
    end
    total++;
    if (wr_q.size() - w0 != 1 || wr_q[wr_q.size()-1].c != c3 + 1 ||
        wr_q[wr_q.size()-1].a !== 8'h01 || wr_q[wr_q.size()-1].d !== 8'h00) begin
      bad++; $display("FAIL unknown_write n=%0d want 1 at %0d addr 01 data 00", wr_q.size() - w0, c3 + 1);
    end
  endtask

  task automatic test_timeout();
    int w0, e0, r0, t0, a, b, c;
    // Abort in WR_DATA
    w0 = wr_q.size(); e0 = err_q.size();
    send_byte(8'hAA, c);
    send_byte(8'h04, b);
    idle(TO + 6);
    total++;
    if (err_q.size() - e0 != 1 || err_q[err_q.size()-1] != b + TO + 2) begin
      bad++; $display("FAIL timeout_err n=%0d want 1 at %0d", err_q.size() - e0, b + TO + 2);
    end
    total++;
    if (wr_q.size() != w0 || bus.CTRL_BUSY !== 1'b0) begin
      bad++; $display("FAIL timeout_abort wr=%0d busy=%b want 0/0", wr_q.size() - w0, bus.CTRL_BUSY);
    end
    // Fresh frame after abort
    w0 = wr_q.size(); e0 = err_q.size();
    send_byte(8'hAA, c);
    send_byte(8'h02, c);
    send_byte(8'h11, b);
    idle(3);
    total++;
    if (wr_q.size() - w0 != 1 || err_q.size() != e0 || wr_q[wr_q.size()-1].c != b + 1 ||
        wr_q[wr_q.size()-1].a !== 8'h02 || wr_q[wr_q.size()-1].d !== 8'h11) begin
      bad++; $display("FAIL timeout_recover wr=%0d err=%0d want 1/0", wr_q.size() - w0, err_q.size() - e0);
    end
    // Byte arriving in the cycle the count reaches TIMEOUT wins
    w0 = wr_q.size(); e0 = err_q.size();
    send_byte(8'hAA, a);
    idle(TO);
    send_byte(8'h0E, c);
    send_byte(8'h77, b);
    idle(3);
    total++;
    if (wr_q.size() - w0 != 1 || err_q.size() != e0 || wr_q[wr_q.size()-1].a !== 8'h0E ||
        wr_q[wr_q.size()-1].d !== 8'h77) begin
      bad++; $display("FAIL timeout_edge_win wr=%0d err=%0d want 1/0", wr_q.size() - w0, err_q.size() - e0);
    end
    // One cycle later the frame has already been aborted
    w0 = wr_q.size(); e0 = err_q.size();
    send_byte(8'hAA, a);
    idle(TO + 1);
    send_byte(8'h0E, c);
    idle(3);
    total++;
    if (err_q.size() - e0 != 2 || err_q[e0] != a + TO + 2 || err_q[e0+1] != a + TO + 3 ||
        wr_q.size() != w0) begin
      bad++; $display("FAIL timeout_edge_late err=%0d wr=%0d want 2 at %0d,%0d and 0", err_q.size() - e0,
                      wr_q.size() - w0, a + TO + 2, a + TO + 3);
    end
    // Register file never answers: abort out of RD_WAIT
    r0 = rd_q.size(); t0 = tx_q.size(); e0 = err_q.size();
    rd_delay = -1;
    send_byte(8'hBB, c);
    send_byte(8'h0A, b);
    idle(TO + 6);
    total++;
    if (err_q.size() - e0 != 1 || err_q[err_q.size()-1] != b + TO + 2 || rd_q.size() - r0 != 1 ||
        tx_q.size() != t0) begin
      bad++; $display("FAIL timeout_rdwait err=%0d rd=%0d tx=%0d want 1@%0d/1/0", err_q.size() - e0,
                      rd_q.size() - r0, tx_q.size() - t0, b + TO + 2);
    end
    rd_delay = 1;
  endtask

  task automatic test_drop();
    int t0, e0, c, b;
    t0 = tx_q.size(); e0 = err_q.size();
    rd_delay = 3;
    bus.TX_BUSY = 1'b1;
    send_byte(8'hBB, c);
    send_byte(8'h05, b);
    tick();
    send_byte(8'($urandom), c);
    while (cyc < b + 7) tick();
    send_byte(8'hAA, c);
    while (cyc < b + 10) tick();
    bus.TX_BUSY = 1'b0;
    idle(4);
    total++;
    if (err_q.size() - e0 != 2 || err_q[e0] != b + 3 || err_q[e0+1] != b + 8) begin
      bad++; $display("FAIL drop_err n=%0d want 2 at %0d,%0d", err_q.size() - e0, b + 3, b + 8);
    end
    total++;
    if (tx_q.size() - t0 != 1 || tx_q[tx_q.size()-1].c != b + 11 || tx_q[tx_q.size()-1].d !== 8'h3C) begin
      bad++; $display("FAIL drop_tx n=%0d want 1 at %0d data 3c", tx_q.size() - t0, b + 11);
    end
    rd_delay = 1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) ref_regs[i] = env_regs[i];
    for (int it = 0; it < 40; it++) begin
      int kind, w0, r0, t0, e0, c, b, g, d, hold, cap;
      logic [7:0] ab, db;
      w0 = wr_q.size(); r0 = rd_q.size(); t0 = tx_q.size(); e0 = err_q.size();
      kind = $urandom_range(0, 2);
      g = $urandom_range(1, TO);
      ab = 8'($urandom);
      db = 8'($urandom);
      if (kind == 0) begin
        send_byte(8'hAA, c); idle(g - 1);
        send_byte(ab, c);    idle(g - 1);
        send_byte(db, b);
        ref_regs[ab[3:0]] = db;
        idle(2);
        total++;
        if (wr_q.size() - w0 != 1 || err_q.size() != e0 || wr_q[wr_q.size()-1].c != b + 1 ||
            wr_q[wr_q.size()-1].a !== 8'(ab[3:0]) || wr_q[wr_q.size()-1].d !== db) begin
          bad++; $display("FAIL rand_write it=%0d n=%0d err=%0d want 1@%0d a=%h d=%h", it,
                          wr_q.size() - w0, err_q.size() - e0, b + 1, ab[3:0], db);
        end
      end else if (kind == 1) begin
        d = $urandom_range(0, 3);
        hold = $urandom_range(0, 4);
        rd_delay = d;
        bus.TX_BUSY = (hold > 0);
        send_byte(8'hBB, c); idle(g - 1);
        send_byte(ab, b);
        cap = b + 1 + d;
        if (hold > 0) begin
          while (cyc < cap + 1 + hold) tick();
          bus.TX_BUSY = 1'b0;
        end
        while (cyc < cap + hold + 4) tick();
        total++;
        if (rd_q.size() - r0 != 1 || rd_q[rd_q.size()-1].c != b + 1 ||
            rd_q[rd_q.size()-1].a !== 8'(ab[3:0])) begin
          bad++; $display("FAIL rand_rden it=%0d n=%0d want 1@%0d a=%h", it, rd_q.size() - r0, b + 1, ab[3:0]);
        end
        total++;
        if (tx_q.size() - t0 != 1 || err_q.size() != e0 || tx_q[tx_q.size()-1].c != cap + 2 + hold ||
            tx_q[tx_q.size()-1].d !== ref_regs[ab[3:0]]) begin
          bad++; $display("FAIL rand_tx it=%0d n=%0d err=%0d want 1@%0d d=%h", it, tx_q.size() - t0,
                          err_q.size() - e0, cap + 2 + hold, ref_regs[ab[3:0]]);
        end
      end else begin
        while (db == 8'hAA || db == 8'hBB) db = 8'($urandom);
        send_byte(db, c);
        idle(2);
        total++;
        if (err_q.size() - e0 != 1 || err_q[err_q.size()-1] != c + 1 || wr_q.size() != w0 ||
            rd_q.size() != r0) begin
          bad++; $display("FAIL rand_junk it=%0d byte=%h err=%0d want 1@%0d", it, db, err_q.size() - e0, c + 1);
        end
      end
      total++;
      if (bus.CTRL_BUSY !== 1'b0) begin
        bad++; $display("FAIL rand_idle it=%0d ctrl_busy got=%b want=0", it, bus.CTRL_BUSY);
      end
      idle($urandom_range(0, 2));
    end
    rd_delay = 1;
  endtask

  task automatic test_reset_midframe();
    int w0, e0, c;
    send_byte(8'hAA, c);
    send_byte(8'h06, c);
    idle(2);
    total++;
    if (bus.CTRL_BUSY !== 1'b1 || bus.REG_ADDR !== 4'h6) begin
      bad++; $display("FAIL rst_pre busy=%b addr=%h want 1/6", bus.CTRL_BUSY, bus.REG_ADDR);
    end
    RST = 1'b0;
    #1;
    total++;
    if (all_outs() !== 25'd0) begin
      bad++; $display("FAIL rst_async got=%h want=0", all_outs());
    end
    idle(3);
    w0 = wr_q.size(); e0 = err_q.size();
    RST = 1'b1;
    idle(2);
    send_byte(8'h33, c);
    idle(3);
    total++;
    if (err_q.size() - e0 != 1 || err_q[err_q.size()-1] != c + 1 || wr_q.size() != w0) begin
      bad++; $display("FAIL rst_after err=%0d wr=%0d want 1@%0d/0", err_q.size() - e0, wr_q.size() - w0, c + 1);
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (multi_strobe != 0) begin
      bad++; $display("FAIL strobe_exclusive cycles=%0d want=0", multi_strobe);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_tx_busy();
    test_unknown();
    test_timeout();
    test_drop();
    test_back_to_back();
    test_reset_midframe();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
